// File: rtl/serial_subtractor_if.sv
// Handshake bundle for serial_subtractor: operand side, result side and status.
// The overflow signal is present only when SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
`ifdef SUB_OVERFLOW_EN
    logic             overflow;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, busy, overflow
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, busy, overflow
    );
`else
    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, busy
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, busy
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, one full-subtractor cell, LSB first over WIDTH cycles.
// Optional signed-overflow flag is built when SUB_OVERFLOW_EN is defined.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int            CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic [WIDTH-1:0] diff_next;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             d;
    logic             br_next;

    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;

`ifdef SUB_OVERFLOW_EN
    logic             a_msb;
    logic             overflow_r;
`endif

    // The single full-subtractor cell; diff_next is the shift register after this bit lands.
    always_comb begin
        d         = a_sr[0] ^ b_sr[0] ^ br;
        br_next   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        diff_next = (diff_sr >> 1) | (WIDTH'(d) << (WIDTH - 1));
    end

    // NOTE: every register here uses <= so all flops sample the same pre-edge values;
    // a blocking = would let later statements see already-updated state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a_sr        <= '0;
            b_sr        <= '0;
            diff_sr     <= '0;
            cnt         <= '0;
            br          <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            diff_r      <= '0;
            bout_r      <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            a_msb       <= 1'b0;
            overflow_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr       <= bus.a;
                        b_sr       <= bus.b;
                        br         <= bus.bin;
                        diff_sr    <= '0;
                        cnt        <= '0;
                        state      <= SHIFT;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
`ifdef SUB_OVERFLOW_EN
                        a_msb      <= bus.a[WIDTH-1];
`endif
                    end
                end

                SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= diff_next;
                    br      <= br_next;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST_BIT) begin
                        // Results are published only here so they stay put outside DONE.
                        state       <= DONE;
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                        diff_r      <= diff_next;
                        bout_r      <= br_next;
`ifdef SUB_OVERFLOW_EN
                        overflow_r  <= (a_msb != b_sr[0]) && (d != a_msb);
`endif
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end

                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.diff      = diff_r;
    assign bus.bout      = bout_r;
`ifdef SUB_OVERFLOW_EN
    assign bus.overflow  = overflow_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=1 with hand-computed results.
// Overflow checks are compiled in when SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(1)) bus1 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    serial_subtractor #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Input handshake in cycle 0; returns in cycle 1.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int n = 0;
        while (!bus8.in_ready && n < 20) begin
            tick();
            n++;
        end
        check("w8_in_ready", 32'(bus8.in_ready), 1);
        bus8.a        = a;
        bus8.b        = b;
        bus8.bin      = bin;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
    endtask

    task automatic wait_done8(output int lat);
        lat = 1;
        while (!bus8.out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish8();
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        check("w8_in_ready_after", 32'(bus8.in_ready), 1);
        check("w8_out_valid_after", 32'(bus8.out_valid), 0);
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic [7:0] exp_diff, input logic exp_bout,
                       input logic exp_ovf);
        int lat;
        start8(a, b, bin);
        check({tag, "_busy"}, 32'(bus8.busy), 1);
        wait_done8(lat);
        check({tag, "_latency"}, 32'(lat), 9);
        check({tag, "_diff"}, 32'(bus8.diff), 32'(exp_diff));
        check({tag, "_bout"}, 32'(bus8.bout), 32'(exp_bout));
`ifdef SUB_OVERFLOW_EN
        check({tag, "_overflow"}, 32'(bus8.overflow), 32'(exp_ovf));
`endif
        finish8();
    endtask

    task automatic op1(input logic [2:0] abc, input logic exp_d, input logic exp_b);
        int lat;
        int n = 0;
        while (!bus1.in_ready && n < 20) begin
            tick();
            n++;
        end
        bus1.a        = abc[2];
        bus1.b        = abc[1];
        bus1.bin      = abc[0];
        bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        check($sformatf("w1_%0d_busy", abc), 32'(bus1.busy), 1);
        lat = 1;
        while (!bus1.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check($sformatf("w1_%0d_latency", abc), 32'(lat), 2);
        check($sformatf("w1_%0d_diff", abc), 32'(bus1.diff), 32'(exp_d));
        check($sformatf("w1_%0d_bout", abc), 32'(bus1.bout), 32'(exp_b));
        bus1.out_ready = 1'b1;
        tick();
        bus1.out_ready = 1'b0;
        check($sformatf("w1_%0d_in_ready", abc), 32'(bus1.in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Full-subtractor truth table indexed by {a, b, bin}.
        logic [7:0] d_tab = 8'b1001_0110;
        logic [7:0] b_tab = 8'b1000_1110;
        int lat;

        bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0; bus8.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0; bus1.out_ready = 1'b0;

        rst = 1'b1;
        tick();
        tick();
        check("rst_in_ready", 32'(bus8.in_ready), 1);
        check("rst_out_valid", 32'(bus8.out_valid), 0);
        check("rst_busy", 32'(bus8.busy), 0);
        check("rst_diff", 32'(bus8.diff), 0);
        check("rst_bout", 32'(bus8.bout), 0);
`ifdef SUB_OVERFLOW_EN
        check("rst_overflow", 32'(bus8.overflow), 0);
`endif
        rst = 1'b0;
        tick();

        op8("sub_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        op8("sub_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        op8("sub_10_10_b", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);
        op8("sub_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        op8("sub_7f_01", 8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0);
        op8("sub_7f_ff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        op8("sub_80_00_b", 8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1);

        // Backpressure: result held for 5 cycles while a stray in_valid pulse arrives.
        start8(8'h37, 8'h12, 1'b0);
        wait_done8(lat);
        check("bp_latency", 32'(lat), 9);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp_out_valid_%0d", c), 32'(bus8.out_valid), 1);
            check($sformatf("bp_diff_%0d", c), 32'(bus8.diff), 32'h25);
            check($sformatf("bp_bout_%0d", c), 32'(bus8.bout), 0);
            if (c == 1) begin
                bus8.a        = 8'hAA;
                bus8.b        = 8'h01;
                bus8.bin      = 1'b1;
                bus8.in_valid = 1'b1;
            end else if (c == 2) begin
                bus8.in_valid = 1'b0;
            end
            tick();
        end
        check("bp_diff_end", 32'(bus8.diff), 32'h25);
        finish8();
        tick();
        check("bp_no_capture", 32'(bus8.in_ready), 1);
        check("bp_no_busy", 32'(bus8.busy), 0);

        // Reset sampled at the end of the 4th SHIFT cycle.
        start8(8'h5A, 8'h3C, 1'b0);
        tick();
        tick();
        tick();
        check("mid_busy", 32'(bus8.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_in_ready", 32'(bus8.in_ready), 1);
        check("mid_out_valid", 32'(bus8.out_valid), 0);
        check("mid_busy_clear", 32'(bus8.busy), 0);
        check("mid_diff", 32'(bus8.diff), 0);
        check("mid_bout", 32'(bus8.bout), 0);
        tick();
        check("mid_stays_idle", 32'(bus8.out_valid), 0);
        op8("sub_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            op1(3'(i), d_tab[i], b_tab[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
